alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Multi-cycle control/issue unit that drives the 8-bit ALU: fetches 16-bit instructions, reads a 4x8 register file, issues operands and ALUop, captures ALUout and Z/N, writes back, and branches on the latched flags.
- Sits between instruction memory (req/valid handshake) and the combinational ALU, which is instantiated at top level and wired to the alu_* ports.

Parameters:
- DATA_W, 8, register/ALU data width
- PC_W, 8, program counter width
- RESET_PC, 0, PC value loaded on reset and on start

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  pulse; leaves IDLE and begins fetching at RESET_PC
- instr_req  out  1  fetch request, held high until accepted
- instr_addr  out  PC_W  current PC
- instr_valid  in  1  instruction word valid (accepted only while instr_req=1)
- instr  in  16  instruction word
- alu_a  out  DATA_W  ALU operand A
- alu_b  out  DATA_W  ALU operand B
- alu_op  out  3  ALU opcode (000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR)
- alu_out  in  DATA_W  ALU result
- alu_z  in  1  ALU zero flag
- alu_n  in  1  ALU negative flag
- flag_z  out  1  latched zero flag
- flag_n  out  1  latched negative flag
- busy  out  1  high in any state except IDLE
- dbg_sel  in  2  register index for debug read
- dbg_data  out  DATA_W  combinational read of reg[dbg_sel]

Behaviour:
- Instruction format: op=instr[15:13], rd=[12:11], rs1=[10:9], rs2=[8:7], imm=[7:0].
- op 000-100: rd <= alu(reg[rs1], reg[rs2]) with alu_op=op; flag_z/flag_n <= alu_z/alu_n.
- op 101 LI: rd <= imm; flags unchanged; alu_* driven to 0.
- op 110 BZ: if flag_z, PC <= imm, else PC+1. op 111 BN: same using flag_n. Flags unchanged.
- States: IDLE, FETCH, EXEC.
  - IDLE: instr_req=0, busy=0. On start=1, PC <= RESET_PC and go to FETCH.
  - FETCH: instr_req=1, instr_addr=PC. On instr_valid=1, latch instr into IR and go to EXEC. Otherwise stay; wait is unbounded.
  - EXEC (exactly 1 cycle): alu_a=reg[rs1], alu_b=reg[rs2], alu_op=op, all driven combinationally from IR. At the closing edge, sample alu_out/alu_z/alu_n, write rd and flags, update PC, and return to FETCH.
- Outside EXEC, and in EXEC for op 101-111: alu_a=0, alu_b=0, alu_op=000.
- Latency: one instruction = FETCH cycles + 1. With zero-wait memory (instr_valid in the first FETCH cycle), 2 cycles per instruction.
- PC increments modulo 2^PC_W (255 -> 0). Branch target is absolute imm.
- instr_valid outside FETCH is ignored. start outside IDLE is ignored.
- rd == rs1/rs2 is legal: operands are read before the write edge.
- No halt opcode. The sequencer runs until rst.
- Reset (synchronous, any state, including mid-FETCH or EXEC): state=IDLE, PC=RESET_PC, IR=0, reg[0..3]=0, flag_z=0, flag_n=0, instr_req=0, busy=0, alu_*=0.
- Register write and flag update in the same cycle as rst=1 are suppressed.

Decomposition:
- Shared package alu_pkg: ALUop encodings (ALU_ADD..ALU_XOR), instruction opcodes (OP_LI, OP_BZ, OP_BN), field bit positions, state encoding.
- One natural sub-module: seq_regfile (4 x DATA_W; two combinational read ports plus debug read, one synchronous write port, synchronous clear on rst).

Test Plan:
- rst, then start. Memory returns LI r1,5; LI r2,3; SUB r3,r1,r2 (zero-wait) -> reg3=2, flag_z=0, flag_n=0. During SUB EXEC: alu_a=5, alu_b=3, alu_op=001. Each instruction takes 2 cycles.
- LI r1,3; LI r2,5; SUB r0,r1,r2 -> reg0=0xFE, flag_n=1, flag_z=0. Then XOR r0,r0,r0 -> reg0=0, flag_z=1, flag_n=0.
- flag_z=1, BZ 0x40 at PC=0x10 -> next instr_addr=0x40. With flag_z=0, the same BZ -> instr_addr=0x11. Repeat with BN/flag_n. LI leaves flags unchanged.
- Memory stalls instr_valid for 4 cycles -> instr_req and instr_addr held stable, no register change. Spurious instr_valid during EXEC/IDLE -> ignored.
- PC=0xFF executing ADD -> next instr_addr=0x00 (wrap).
- Assert rst during EXEC of ADD r1,r1,r1 with r1=7 -> reg1 stays cleared to 0, state IDLE, busy=0, instr_req=0 next cycle. start restarts at instr_addr=0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the ALU sequencer
// Provides ALU/instruction opcodes, instruction field positions, FSM states.
package alu_pkg;
  localparam int OP_HI  = 15;
  localparam int OP_LO  = 13;
  localparam int RD_HI  = 12;
  localparam int RD_LO  = 11;
  localparam int RS1_HI = 10;
  localparam int RS1_LO = 9;
  localparam int RS2_HI = 8;
  localparam int RS2_LO = 7;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    OP_LI   = 3'b101,
    OP_BZ   = 3'b110,
    OP_BN   = 3'b111
  } op_e;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC} state_e;
  function automatic logic is_alu_op(input op_e op);
    return op <= ALU_XOR;
  endfunction
endpackage

// File: rtl/seq_regfile.sv
// seq_regfile: 4 x DATA_W register file
// Ports: clk/rst (sync clear), we/waddr/wdata write port,
// raddr1/raddr2 -> rdata1/rdata2 and dbg_sel -> dbg_data combinational reads.
module seq_regfile #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [1:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        raddr1,
  input  logic [1:0]        raddr2,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] dbg_data
);
  logic [DATA_W-1:0] regs [4];
  assign rdata1   = regs[raddr1];
  assign rdata2   = regs[raddr2];
  assign dbg_data = regs[dbg_sel];
  always_ff @(posedge clk) begin
    if (rst) regs <= '{default: '0};
    else if (we) regs[waddr] <= wdata;
  end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: fetch/exec control unit driving an external combinational ALU
// Ports: clk/rst/start control; instr_req/instr_addr/instr_valid/instr fetch
// handshake; alu_a/alu_b/alu_op issue and alu_out/alu_z/alu_n result;
// flag_z/flag_n latched flags; busy; dbg_sel/dbg_data register peek.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int              DATA_W   = 8,
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              instr_req,
  output logic [PC_W-1:0]   instr_addr,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_z,
  input  logic              alu_n,
  output logic              flag_z,
  output logic              flag_n,
  output logic              busy,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);
  state_e            state;
  logic [PC_W-1:0]   pc;
  logic [15:0]       ir;
  op_e               op;
  logic [1:0]        rd, rs1, rs2;
  logic [7:0]        imm;
  logic [DATA_W-1:0] rdata1, rdata2, wdata;
  logic              exec, alu_issue, we, take;
  assign op         = op_e'(ir[OP_HI:OP_LO]);
  assign rd         = ir[RD_HI:RD_LO];
  assign rs1        = ir[RS1_HI:RS1_LO];
  assign rs2        = ir[RS2_HI:RS2_LO];
  assign imm        = ir[IMM_HI:IMM_LO];
  assign exec       = state == S_EXEC;
  assign alu_issue  = exec && is_alu_op(op);
  assign we         = alu_issue || (exec && op == OP_LI);
  assign wdata      = alu_issue ? alu_out : DATA_W'(imm);
  assign take       = (op == OP_BZ && flag_z) || (op == OP_BN && flag_n);
  assign instr_req  = state == S_FETCH;
  assign instr_addr = pc;
  assign busy       = state != S_IDLE;
  assign alu_a      = alu_issue ? rdata1 : '0;
  assign alu_b      = alu_issue ? rdata2 : '0;
  assign alu_op     = alu_issue ? op : ALU_ADD;
  seq_regfile #(.DATA_W(DATA_W)) u_rf (
    .clk, .rst, .we, .waddr(rd), .wdata, .raddr1(rs1), .raddr2(rs2),
    .dbg_sel, .rdata1, .rdata2, .dbg_data
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      pc     <= RESET_PC;
      ir     <= '0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          pc    <= RESET_PC;
          state <= S_FETCH;
        end
        S_FETCH: if (instr_valid) begin
          ir    <= instr;
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (alu_issue) {flag_z, flag_n} <= {alu_z, alu_n};
          pc    <= take ? PC_W'(imm) : pc + 1'b1;
          state <= S_FETCH;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized bench with instruction-level reference model
module tb_alu_sequencer;
  logic        clk = 0, rst = 1, start = 0, instr_valid = 0;
  logic [15:0] instr = 0;
  logic [1:0]  dbg_sel = 0;
  logic        instr_req, flag_z, flag_n, busy, alu_z, alu_n;
  logic [7:0]  instr_addr, alu_a, alu_b, alu_out, dbg_data;
  logic [2:0]  alu_op;
  logic [15:0] prog [256];
  int total = 0, bad = 0, cycles = 0, stall_pct = 0, t0;
  bit rnd = 0, chk_en = 0;
  int          m_ph = 0, m_pc = 0;
  logic [15:0] m_ir = 0;
  logic [7:0]  m_reg [4] = '{default: 0};
  logic        m_fz = 0, m_fn = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      default: return 8'd0;
    endcase
  endfunction

  assign alu_out = alu_f(alu_op, alu_a, alu_b);
  assign alu_z   = alu_out == 8'd0;
  assign alu_n   = alu_out[7];

  alu_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .instr_req(instr_req), .instr_addr(instr_addr),
    .instr_valid(instr_valid), .instr(instr), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_z(alu_z), .alu_n(alu_n), .flag_z(flag_z), .flag_n(flag_n),
    .busy(busy), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cycles);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_ph = 0; m_pc = 0; m_ir = 0; m_fz = 0; m_fn = 0;
      for (int i = 0; i < 4; i++) m_reg[i] = 0;
    end else if (m_ph == 0) begin
      if (start) begin m_pc = 0; m_ph = 1; end
    end else if (m_ph == 1) begin
      if (instr_valid) begin m_ir = instr; m_ph = 2; end
    end else begin
      int op, nxt;
      logic [7:0] r, imm;
      op  = m_ir[15:13];
      imm = m_ir[7:0];
      nxt = (m_pc + 1) % 256;
      if (op < 5) begin
        r = alu_f(3'(op), m_reg[m_ir[10:9]], m_reg[m_ir[8:7]]);
        m_reg[m_ir[12:11]] = r;
        m_fz = r == 0;
        m_fn = r[7];
      end else if (op == 5) m_reg[m_ir[12:11]] = imm;
      else if ((op == 6 && m_fz) || (op == 7 && m_fn)) nxt = imm;
      m_pc = nxt;
      m_ph = 1;
    end
  end

  always @(negedge clk) if (chk_en) begin
    bit iss;
    iss = m_ph == 2 && m_ir[15:13] < 5;
    chk("instr_req", instr_req, m_ph == 1);
    if (m_ph == 1) chk("instr_addr", instr_addr, m_pc);
    chk("busy", busy, m_ph != 0);
    chk("flag_z", flag_z, m_fz);
    chk("flag_n", flag_n, m_fn);
    chk("alu_a", alu_a, iss ? m_reg[m_ir[10:9]] : 8'd0);
    chk("alu_b", alu_b, iss ? m_reg[m_ir[8:7]] : 8'd0);
    chk("alu_op", alu_op, iss ? m_ir[15:13] : 3'd0);
    chk("dbg_data", dbg_data, m_reg[dbg_sel]);
  end

  task automatic cyc();
    @(negedge clk); #2; cycles++;
    instr_valid = instr_req ? ($urandom_range(99) >= stall_pct) : ($urandom_range(3) == 0);
    instr = instr_req ? prog[instr_addr] : 16'($urandom);
    dbg_sel = 2'($urandom);
    if (rnd) begin
      start = $urandom_range(7) == 0;
      rst = $urandom_range(299) == 0;
    end
  endtask

  task automatic wait_addr(input int a);
    int n = 0;
    while (!(instr_req && instr_addr == a) && n < 64) begin cyc(); n++; end
    chk("reach_addr", (instr_req && instr_addr == a) ? a : instr_addr, a);
  endtask

  task automatic chk_reg(input int idx, input logic [7:0] exp);
    dbg_sel = 2'(idx);
    #1;
    chk("reg_lit", dbg_data, exp);
  endtask

  function automatic logic [15:0] enc_r(input int op, input int rd, input int rs1, input int rs2);
    return {3'(op), 2'(rd), 2'(rs1), 2'(rs2), 7'd0};
  endfunction

  function automatic logic [15:0] enc_i(input int op, input int rd, input int imm);
    return {3'(op), 2'(rd), 3'd0, 8'(imm)};
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) prog[i] = 16'($urandom);
    prog[0]    = enc_i(5, 1, 5);
    prog[1]    = enc_i(5, 2, 3);
    prog[2]    = enc_r(1, 3, 1, 2);
    prog[3]    = enc_i(5, 1, 3);
    prog[4]    = enc_i(5, 2, 5);
    prog[5]    = enc_r(1, 0, 1, 2);
    prog[6]    = enc_r(4, 0, 0, 0);
    prog[7]    = enc_i(6, 0, 8'h10);
    prog[8'h10] = enc_i(6, 0, 8'h40);
    prog[8'h40] = enc_r(1, 0, 1, 2);
    prog[8'h41] = enc_i(6, 0, 8'h10);
    prog[8'h42] = enc_i(7, 0, 8'h80);
    prog[8'h80] = enc_i(5, 3, 0);
    prog[8'h81] = enc_i(7, 0, 8'hFF);
    prog[8'hFF] = enc_r(0, 2, 2, 2);
    cyc();
    chk_en = 1;
    cyc();
    chk("rst_busy", busy, 0);
    chk("rst_req", instr_req, 0);
    chk("rst_fz", flag_z, 0);
    rst = 0; start = 1;
    cyc();
    start = 0;
    wait_addr(0); t0 = cycles;
    wait_addr(2);
    cyc();
    chk("sub_a", alu_a, 5);
    chk("sub_b", alu_b, 3);
    chk("sub_op", alu_op, 1);
    wait_addr(3);
    chk("cpi", cycles - t0, 6);
    chk_reg(3, 8'd2);
    chk("sub_fz", flag_z, 0);
    chk("sub_fn", flag_n, 0);
    wait_addr(6);
    chk_reg(0, 8'hFE);
    chk("neg_fn", flag_n, 1);
    chk("neg_fz", flag_z, 0);
    wait_addr(7);
    chk_reg(0, 8'h00);
    chk("xor_fz", flag_z, 1);
    chk("xor_fn", flag_n, 0);
    wait_addr(8'h10); t0 = cycles;
    wait_addr(8'h40);
    chk("bz_taken", cycles - t0, 2);
    wait_addr(8'h41); t0 = cycles;
    wait_addr(8'h42);
    chk("bz_not_taken", cycles - t0, 2);
    wait_addr(8'h80);
    wait_addr(8'h81);
    chk("li_keeps_fn", flag_n, 1);
    chk("li_keeps_fz", flag_z, 0);
    wait_addr(8'hFF); t0 = cycles;
    wait_addr(8'h00);
    chk("pc_wrap", cycles - t0, 2);
    chk_reg(2, 8'd10);
    for (int i = 0; i < 256; i++) prog[i] = 16'($urandom);
    stall_pct = 40; rnd = 1;
    repeat (4000) cyc();
    rnd = 0; start = 0; rst = 1; stall_pct = 0;
    prog[0] = enc_i(5, 1, 7);
    prog[1] = enc_r(0, 1, 1, 1);
    cyc(); cyc();
    rst = 0; start = 1;
    cyc();
    start = 0;
    wait_addr(1);
    cyc();
    chk("add_a", alu_a, 7);
    chk("add_op", alu_op, 0);
    rst = 1;
    cyc();
    rst = 0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_req", instr_req, 0);
    chk_reg(1, 8'd0);
    start = 1;
    cyc();
    start = 0;
    chk("restart_req", instr_req, 1);
    chk("restart_addr", instr_addr, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
